nasti_err_slave: RTL and testbench

- Terminating NASTI slave on the escape output of the address demultiplexer (port 0 with escape enabled), or behind any unmapped window.
- Accepts every write and read addressed to it and drains all write data.
- Returns an error response per transaction: one B per write, and exactly len+1 R beats per read, with the last beat marked.
- Keeps unmapped accesses from hanging the master; no storage beyond one outstanding write and one outstanding read.

---
 rtl/nasti_pkg.sv | 13 +
 rtl/nasti_err_slave_r.sv | 82 ++++++++
 rtl/nasti_err_slave.sv | 118 +++++++++++
 tb/tb_nasti_err_slave.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nasti_pkg.sv
// Shared NASTI encodings and types.
package nasti_pkg;

  localparam int unsigned LEN_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [LEN_W-1:0] len_t;

endpackage

// File: rtl/nasti_err_slave_r.sv
// Read side of the error slave: answers each AR with len+1 error beats.
module nasti_err_slave_r
  import nasti_pkg::*;
#(
  parameter int unsigned ID_WIDTH     = 1,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned USER_WIDTH   = 1,
  parameter bit          LITE_MODE    = 1'b0,
  parameter logic [1:0]  ERR_RESP     = RESP_DECERR,
  parameter logic [DATA_WIDTH-1:0] DATA_PATTERN = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  len_t                  ar_len,
  input  logic [USER_WIDTH-1:0] ar_user,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  output logic                  r_last,
  output logic [USER_WIDTH-1:0] r_user,
  output logic                  r_valid,
  input  logic                  r_ready
);

  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  r_state_e state;
  len_t     len;
  len_t     cnt;
  len_t     len_in;

  assign len_in = LITE_MODE ? '0 : ar_len;
  assign r_data = DATA_PATTERN;
  assign r_resp = ERR_RESP;

  // r_last is precomputed one beat ahead so it stays a plain flop output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= R_IDLE;
      ar_ready <= 1'b1;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_id     <= '0;
      r_user   <= '0;
      len      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        R_IDLE: begin
          if (ar_valid) begin
            state    <= R_DATA;
            ar_ready <= 1'b0;
            r_valid  <= 1'b1;
            r_id     <= ar_id;
            r_user   <= ar_user;
            len      <= len_in;
            cnt      <= '0;
            r_last   <= (len_in == '0);
          end
        end
        R_DATA: begin
          if (r_ready) begin
            if (r_last) begin
              state    <= R_IDLE;
              ar_ready <= 1'b1;
              r_valid  <= 1'b0;
              r_last   <= 1'b0;
            end else begin
              cnt    <= cnt + LEN_W'(1);
              r_last <= ((cnt + LEN_W'(1)) == len);
            end
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/nasti_err_slave.sv
// Terminating NASTI slave: accepts every access and returns an error response.
module nasti_err_slave
  import nasti_pkg::*;
#(
  parameter int unsigned ID_WIDTH     = 1,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned USER_WIDTH   = 1,
  parameter bit          LITE_MODE    = 1'b0,
  parameter logic [1:0]  ERR_RESP     = RESP_DECERR,
  parameter logic [DATA_WIDTH-1:0] DATA_PATTERN = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     aw_id,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic [USER_WIDTH-1:0]   aw_user,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_last,
  input  logic [USER_WIDTH-1:0]   w_user,
  input  logic                    w_valid,
  output logic                    w_ready,
  output logic [ID_WIDTH-1:0]     b_id,
  output logic [1:0]              b_resp,
  output logic [USER_WIDTH-1:0]   b_user,
  output logic                    b_valid,
  input  logic                    b_ready,
  input  logic [ID_WIDTH-1:0]     ar_id,
  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  input  len_t                    ar_len,
  input  logic [USER_WIDTH-1:0]   ar_user,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  output logic [ID_WIDTH-1:0]     r_id,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  output logic                    r_last,
  output logic [USER_WIDTH-1:0]   r_user,
  output logic                    r_valid,
  input  logic                    r_ready
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  w_state_e w_state;

  // Address, write payload and strobes are deliberately discarded
  logic unused_ok;
  assign unused_ok = ^{aw_addr, ar_addr, w_data, w_strb, w_user};

  assign b_resp = ERR_RESP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state  <= W_IDLE;
      aw_ready <= 1'b1;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_id     <= '0;
      b_user   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_valid) begin
            w_state  <= W_DATA;
            aw_ready <= 1'b0;
            w_ready  <= 1'b1;
            b_id     <= aw_id;
            b_user   <= aw_user;
          end
        end
        W_DATA: begin
          if (w_valid && (w_last || LITE_MODE)) begin
            w_state <= W_RESP;
            w_ready <= 1'b0;
            b_valid <= 1'b1;
          end
        end
        W_RESP: begin
          if (b_ready) begin
            w_state  <= W_IDLE;
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  nasti_err_slave_r #(
    .ID_WIDTH     (ID_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .USER_WIDTH   (USER_WIDTH),
    .LITE_MODE    (LITE_MODE),
    .ERR_RESP     (ERR_RESP),
    .DATA_PATTERN (DATA_PATTERN)
  ) u_r (
    .clk      (clk),
    .rst      (rst),
    .ar_id    (ar_id),
    .ar_len   (ar_len),
    .ar_user  (ar_user),
    .ar_valid (ar_valid),
    .ar_ready (ar_ready),
    .r_id     (r_id),
    .r_data   (r_data),
    .r_resp   (r_resp),
    .r_last   (r_last),
    .r_user   (r_user),
    .r_valid  (r_valid),
    .r_ready  (r_ready)
  );

endmodule

// File: tb/tb_nasti_err_slave.sv
// Directed bench for nasti_err_slave with default parameters.
module tb_nasti_err_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] aw_id;
  logic [7:0] aw_addr;
  logic [0:0] aw_user;
  logic       aw_valid;
  logic       aw_ready;
  logic [7:0] w_data;
  logic [0:0] w_strb;
  logic       w_last;
  logic [0:0] w_user;
  logic       w_valid;
  logic       w_ready;
  logic [0:0] b_id;
  logic [1:0] b_resp;
  logic [0:0] b_user;
  logic       b_valid;
  logic       b_ready;
  logic [0:0] ar_id;
  logic [7:0] ar_addr;
  logic [7:0] ar_len;
  logic [0:0] ar_user;
  logic       ar_valid;
  logic       ar_ready;
  logic [0:0] r_id;
  logic [7:0] r_data;
  logic [1:0] r_resp;
  logic       r_last;
  logic [0:0] r_user;
  logic       r_valid;
  logic       r_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nasti_err_slave dut (
    .clk(clk), .rst(rst),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_user(aw_user), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_user(w_user), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_user(b_user), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_user(ar_user), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_user(r_user), .r_valid(r_valid), .r_ready(r_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   beats;
    int   bad_last;
    int   bad_stable;
    logic done;
    logic stalled;
    logic snap_last;
    logic [0:0] snap_id;
    logic [7:0] snap_data;

    rst = 1'b1;
    aw_id = '0; aw_addr = 8'h5a; aw_user = '0; aw_valid = 1'b0;
    w_data = 8'ha5; w_strb = '1; w_last = 1'b0; w_user = '0; w_valid = 1'b0;
    b_ready = 1'b0;
    ar_id = '0; ar_addr = 8'h3c; ar_len = '0; ar_user = '0; ar_valid = 1'b0;
    r_ready = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_aw_ready", aw_ready, 1);
    check("rst_ar_ready", ar_ready, 1);
    check("rst_w_ready", w_ready, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_last", r_last, 0);
    rst = 1'b0;
    tick();

    // Write burst of 4 beats
    aw_valid = 1'b1; aw_id = 1'b1;
    tick();
    aw_valid = 1'b0;
    check("wr_aw_ready_low", aw_ready, 0);
    check("wr_w_ready_n1", w_ready, 1);
    w_valid = 1'b1;
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      w_last = (i == 3);
      if (w_ready) beats++;
      tick();
    end
    w_valid = 1'b0; w_last = 1'b0;
    check("wr_w_handshakes", beats, 4);
    check("wr_b_valid", b_valid, 1);
    check("wr_b_id", b_id, 1);
    check("wr_b_resp", b_resp, 2'b11);
    check("wr_w_ready_off", w_ready, 0);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("wr_b_valid_off", b_valid, 0);
    check("wr_aw_ready_back", aw_ready, 1);

    // Read burst len=3, r_ready held high
    ar_valid = 1'b1; ar_id = 1'b0; ar_len = 8'd3; r_ready = 1'b1;
    tick();
    ar_valid = 1'b0;
    check("rd_ar_ready_low", ar_ready, 0);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("rd4_valid_%0d", b), r_valid, 1);
      check($sformatf("rd4_last_%0d", b), r_last, (b == 3) ? 1 : 0);
      check($sformatf("rd4_resp_%0d", b), r_resp, 2'b11);
      check($sformatf("rd4_data_%0d", b), r_data, 0);
      check($sformatf("rd4_id_%0d", b), r_id, 0);
      tick();
    end
    check("rd4_valid_off", r_valid, 0);
    check("rd4_ar_ready_back", ar_ready, 1);

    // Read burst len=255 with r_ready toggling
    ar_valid = 1'b1; ar_id = 1'b1; ar_len = 8'd255; r_ready = 1'b0;
    tick();
    ar_valid = 1'b0;
    beats = 0; bad_last = 0; bad_stable = 0; done = 1'b0;
    for (int c = 0; c < 1200 && !done; c++) begin
      r_ready = (c % 2 == 0);
      stalled = !r_ready;
      snap_last = r_last; snap_id = r_id; snap_data = r_data;
      if (r_valid && r_ready) begin
        beats++;
        if (r_last !== (beats == 256)) bad_last++;
        if (r_last) done = 1'b1;
      end
      tick();
      if (stalled && (r_valid !== 1'b1 || r_last !== snap_last || r_id !== snap_id || r_data !== snap_data))
        bad_stable++;
    end
    r_ready = 1'b0;
    check("rd256_done", done, 1);
    check("rd256_beats", beats, 256);
    check("rd256_last_only_end", bad_last, 0);
    check("rd256_stable_stall", bad_stable, 0);
    check("rd256_valid_off", r_valid, 0);

    // Simultaneous AW and AR, B held off while R completes
    aw_valid = 1'b1; aw_id = 1'b1; ar_valid = 1'b1; ar_id = 1'b0; ar_len = 8'd1;
    r_ready = 1'b1; b_ready = 1'b0;
    tick();
    aw_valid = 1'b0; ar_valid = 1'b0;
    check("sim_aw_taken", aw_ready, 0);
    check("sim_ar_taken", ar_ready, 0);
    check("sim_w_ready", w_ready, 1);
    check("sim_r_valid", r_valid, 1);
    w_valid = 1'b1; w_last = 1'b1;
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    check("sim_r_last_beat2", r_last, 1);
    check("sim_b_valid", b_valid, 1);
    for (int i = 0; i < 4; i++) tick();
    check("sim_r_done", r_valid, 0);
    check("sim_ar_ready_back", ar_ready, 1);
    check("sim_b_still_valid", b_valid, 1);
    check("sim_b_id", b_id, 1);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("sim_b_done", b_valid, 0);
    check("sim_aw_ready_back", aw_ready, 1);

    // W before AW is held off, then consumed
    w_valid = 1'b1; w_last = 1'b1;
    tick(); tick();
    check("early_w_ready", w_ready, 0);
    check("early_b_valid", b_valid, 0);
    aw_valid = 1'b1; aw_id = 1'b0;
    tick();
    aw_valid = 1'b0;
    check("early_w_ready_on", w_ready, 1);
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    check("early_b_valid_on", b_valid, 1);
    check("early_b_id", b_id, 0);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;

    // Reset mid read burst and mid W_DATA
    aw_valid = 1'b1; aw_id = 1'b1; ar_valid = 1'b1; ar_id = 1'b1; ar_len = 8'd7; r_ready = 1'b1;
    tick();
    aw_valid = 1'b0; ar_valid = 1'b0;
    tick(); tick();
    check("mid_r_valid", r_valid, 1);
    check("mid_r_last", r_last, 0);
    check("mid_w_ready", w_ready, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_r_valid", r_valid, 0);
    check("arst_w_ready", w_ready, 0);
    check("arst_b_valid", b_valid, 0);
    check("arst_aw_ready", aw_ready, 1);
    check("arst_ar_ready", ar_ready, 1);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("post_rst_r_valid", r_valid, 0);
    check("post_rst_b_valid", b_valid, 0);
    check("post_rst_ar_ready", ar_ready, 1);
    check("post_rst_aw_ready", aw_ready, 1);
    ar_valid = 1'b1; ar_id = 1'b1; ar_len = 8'd0;
    tick();
    ar_valid = 1'b0;
    check("len0_r_valid", r_valid, 1);
    check("len0_r_last", r_last, 1);
    check("len0_r_id", r_id, 1);
    tick();
    check("len0_done", r_valid, 0);
    check("len0_ar_ready", ar_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
